// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: instruction request plus ALU strobe / datapath enable bundle.
// mem_ready is present only when ALU_SEQ_MEM_WAIT_EN is defined.
interface alu_op_sequencer_if #(
    parameter int IR_W  = 32,
    parameter int SEL_W = 4
);
    logic             start;
    logic [IR_W-1:0]  ir;
`ifdef ALU_SEQ_MEM_WAIT_EN
    logic             mem_ready;
`endif
    logic [13:0]      alu_op;
    logic             PCout, MARin, Zin, PCin, Read, MDRin, MDRout, IRin;
    logic             Yin, Rout, Rin, Zlowout, Zhighout, LOin, HIin;
    logic [SEL_W-1:0] rout_sel, rin_sel;
    logic             busy, done, illegal;
`ifdef ALU_SEQ_MEM_WAIT_EN
    modport master(output start, ir, mem_ready,
                   input alu_op, PCout, MARin, Zin, PCin, Read, MDRin, MDRout, IRin, Yin, Rout, Rin,
                         Zlowout, Zhighout, LOin, HIin, rout_sel, rin_sel, busy, done, illegal);
    modport slave(input start, ir, mem_ready,
                  output alu_op, PCout, MARin, Zin, PCin, Read, MDRin, MDRout, IRin, Yin, Rout, Rin,
                         Zlowout, Zhighout, LOin, HIin, rout_sel, rin_sel, busy, done, illegal);
`else
    modport master(output start, ir,
                   input alu_op, PCout, MARin, Zin, PCin, Read, MDRin, MDRout, IRin, Yin, Rout, Rin,
                         Zlowout, Zhighout, LOin, HIin, rout_sel, rin_sel, busy, done, illegal);
    modport slave(input start, ir,
                  output alu_op, PCout, MARin, Zin, PCin, Read, MDRin, MDRout, IRin, Yin, Rout, Rin,
                         Zlowout, Zhighout, LOin, HIin, rout_sel, rin_sel, busy, done, illegal);
`endif
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: fetch/execute control-step FSM driving one-hot ALU strobes and datapath enables.
// Optional ALU_SEQ_MEM_WAIT_EN: T1 stretches until mem_ready.
module alu_op_sequencer #(
    parameter int IR_W  = 32,
    parameter int OP_W  = 5,
    parameter int SEL_W = 4
) (
    input logic clock,
    input logic reset,
    alu_op_sequencer_if.slave bus
);
    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, ILL} state_t;
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(3),  OP_SUB = OP_W'(4),  OP_SHR = OP_W'(5),
                                OP_SHRA = OP_W'(6), OP_SHL = OP_W'(7),  OP_ROR = OP_W'(8),
                                OP_ROL = OP_W'(9),  OP_AND = OP_W'(10), OP_OR = OP_W'(11),
                                OP_MUL = OP_W'(15), OP_DIV = OP_W'(16), OP_NEG = OP_W'(17),
                                OP_NOT = OP_W'(18);
    function automatic logic [12:0] op_bit(input logic [OP_W-1:0] o);
        return o == OP_ADD  ? 13'h0001 : o == OP_SUB ? 13'h0002 : o == OP_MUL ? 13'h0004 :
               o == OP_DIV  ? 13'h0008 : o == OP_AND ? 13'h0010 : o == OP_OR  ? 13'h0020 :
               o == OP_SHR  ? 13'h0040 : o == OP_SHRA ? 13'h0080 : o == OP_SHL ? 13'h0100 :
               o == OP_ROR  ? 13'h0200 : o == OP_ROL ? 13'h0400 : o == OP_NEG ? 13'h0800 :
               o == OP_NOT  ? 13'h1000 : 13'h0000;
    endfunction
    function automatic logic is_md(input logic [OP_W-1:0] o);
        return o == OP_MUL || o == OP_DIV;
    endfunction
    function automatic logic is_nn(input logic [OP_W-1:0] o);
        return o == OP_NEG || o == OP_NOT;
    endfunction
    localparam int RA_HI = IR_W - OP_W - 1;
    state_t state, nxt;
    logic [OP_W-1:0] op_q, op_n, ir_op;
    logic [SEL_W-1:0] ra_q, rb_q, rc_q, ra_n, rb_n, rc_n;
    logic [13:0] alu_q, alu_d;
    logic [14:0] en_q, en_d;
    logic [SEL_W-1:0] rout_q, rin_q, rout_d, rin_d;
    logic busy_q, done_q, ill_q, md, r3;
    wire unused_ir = &{1'b0, bus.ir[RA_HI-3*SEL_W:0]};
    assign ir_op = bus.ir[IR_W-1 -: OP_W];
    always_comb begin
        op_n = op_q;
        ra_n = ra_q;
        rb_n = rb_q;
        rc_n = rc_q;
        nxt  = IDLE;
        case (state)
            IDLE: nxt = bus.start ? T0 : IDLE;
            T0:   nxt = T1;
`ifdef ALU_SEQ_MEM_WAIT_EN
            T1:   nxt = bus.mem_ready ? T2 : T1;
`else
            T1:   nxt = T2;
`endif
            T2: begin
                op_n = ir_op;
                ra_n = bus.ir[RA_HI -: SEL_W];
                rb_n = bus.ir[RA_HI-SEL_W -: SEL_W];
                rc_n = bus.ir[RA_HI-2*SEL_W -: SEL_W];
                nxt  = op_bit(ir_op) == '0 ? ILL : is_nn(ir_op) ? T4 : T3;
            end
            T3:      nxt = T4;
            T4:      nxt = T5;
            T5:      nxt = is_md(op_q) ? T6 : IDLE;
            default: nxt = IDLE;
        endcase
    end
    // Outputs are decoded from the next state so the registered copies line up with the state register.
    always_comb begin
        md     = is_md(op_n);
        r3     = !md && !is_nn(op_n);
        alu_d  = {nxt == T0, nxt == T4 ? op_bit(op_n) : 13'h0};
        rout_d = nxt == T3 ? (md ? ra_n : rb_n) : nxt == T4 ? (r3 ? rc_n : rb_n) : '0;
        rin_d  = nxt == T5 && !md ? ra_n : '0;
        en_d   = {nxt == T0, nxt == T0, nxt == T0 || nxt == T4,
                  nxt == T1, nxt == T1, nxt == T1,
                  nxt == T2, nxt == T2,
                  nxt == T3, nxt == T3 || nxt == T4, nxt == T5 && !md,
                  nxt == T1 || nxt == T5, nxt == T6, nxt == T5 && md, nxt == T6};
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= '0;
            ra_q   <= '0;
            rb_q   <= '0;
            rc_q   <= '0;
            alu_q  <= '0;
            en_q   <= '0;
            rout_q <= '0;
            rin_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            state  <= nxt;
            op_q   <= op_n;
            ra_q   <= ra_n;
            rb_q   <= rb_n;
            rc_q   <= rc_n;
            alu_q  <= alu_d;
            en_q   <= en_d;
            rout_q <= rout_d;
            rin_q  <= rin_d;
            busy_q <= nxt != IDLE;
            done_q <= (nxt == T5 && !md) || nxt == T6;
            ill_q  <= nxt == ILL;
        end
    end
    assign bus.alu_op   = alu_q;
    assign {bus.PCout, bus.MARin, bus.Zin, bus.PCin, bus.Read, bus.MDRin, bus.MDRout, bus.IRin,
            bus.Yin, bus.Rout, bus.Rin, bus.Zlowout, bus.Zhighout, bus.LOin, bus.HIin} = en_q;
    assign bus.rout_sel = rout_q;
    assign bus.rin_sel  = rin_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.illegal  = ill_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: table-driven instruction runs plus reset-abort and back-to-back sequences.
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int fails = 0;

    alu_op_sequencer_if #(.IR_W(32), .SEL_W(4)) bus();
    alu_op_sequencer #(.IR_W(32), .OP_W(5), .SEL_W(4)) dut(.clock(clk), .reset(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        int          lat;
        int          yins;
        logic [3:0]  t3_sel;
        logic [13:0] t4_op;
        logic [3:0]  t4_sel;
        int          rins;
        logic [3:0]  rin_sel;
        int          hilo;
        int          ills;
    } vec_t;
    vec_t vecs[15];

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int ra, input int rb, input int rc);
        return 32'((op << 27) | (ra << 23) | (rb << 19) | (rc << 15));
    endfunction

    function automatic logic [39:0] all_out();
        return {bus.alu_op, bus.PCout, bus.MARin, bus.Zin, bus.PCin, bus.Read, bus.MDRin, bus.MDRout,
                bus.IRin, bus.Yin, bus.Rout, bus.Rin, bus.Zlowout, bus.Zhighout, bus.LOin, bus.HIin,
                bus.rout_sel, bus.rin_sel, bus.busy, bus.done, bus.illegal};
    endfunction

    function automatic logic inv_bad();
        return $countones(bus.alu_op) > 1 || (!bus.Rout && bus.rout_sel != 0) ||
               (!bus.Rin && bus.rin_sel != 0) ||
               $countones({bus.Zlowout, bus.Zhighout, bus.MDRout, bus.PCout, bus.Rout}) > 1;
    endfunction

    task automatic run(input vec_t v, input int id, input int wait_n);
        int done_cyc = 0, done_cnt = 0, ill_cnt = 0, yin_cnt = 0, rin_cnt = 0;
        int lo_cnt = 0, hi_cnt = 0, t1_cnt = 0, t1_full = 0, t2_cnt = 0, bad = 0;
        logic [3:0] t3s = 0, t4s = 0, rs = 0;
        logic [13:0] t4o = 0;
        logic [16:0] t0 = 0;
        logic ended = 0;
        @(negedge clk);
        bus.ir = v.ir;
        bus.start = 1'b1;
`ifdef ALU_SEQ_MEM_WAIT_EN
        bus.mem_ready = (wait_n == 0);
`endif
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= 24 && !ended; c++) begin
            @(negedge clk);
            if (inv_bad()) bad++;
            if (!bus.busy) ended = 1'b1;
            else begin
                if (c == 1) t0 = {bus.PCout, bus.MARin, bus.Zin, bus.alu_op};
                if (bus.PCin) t1_cnt++;
                if ({bus.Zlowout, bus.PCin, bus.Read, bus.MDRin} == 4'hF) t1_full++;
                if ({bus.MDRout, bus.IRin} == 2'b11) t2_cnt++;
                if (bus.Yin) begin yin_cnt++; t3s = bus.rout_sel; end
                if (bus.alu_op[12:0] != 0 && bus.Zin) begin t4o = bus.alu_op; t4s = bus.rout_sel; end
                if (bus.Rin && bus.Zlowout) begin rin_cnt++; rs = bus.rin_sel; end
                if (bus.LOin && bus.Zlowout) lo_cnt++;
                if (bus.HIin && bus.Zhighout) hi_cnt++;
                if (bus.illegal) ill_cnt++;
                if (bus.done) begin done_cnt++; if (done_cyc == 0) done_cyc = c; end
`ifdef ALU_SEQ_MEM_WAIT_EN
                if (t1_cnt == wait_n + 1) bus.mem_ready = 1'b1;
`endif
            end
        end
`ifdef ALU_SEQ_MEM_WAIT_EN
        bus.mem_ready = 1'b1;
`endif
        chk($sformatf("v%0d ended", id), ended, 1);
        chk($sformatf("v%0d t0", id), t0, {3'b111, 14'h2000});
        chk($sformatf("v%0d t1_cycles", id), t1_cnt, 1 + wait_n);
        chk($sformatf("v%0d t1_outputs", id), t1_full, 1 + wait_n);
        chk($sformatf("v%0d t2", id), t2_cnt, 1);
        chk($sformatf("v%0d latency", id), done_cyc, v.ills != 0 ? 0 : v.lat + wait_n);
        chk($sformatf("v%0d done_count", id), done_cnt, v.ills != 0 ? 0 : 1);
        chk($sformatf("v%0d illegal_count", id), ill_cnt, v.ills);
        chk($sformatf("v%0d yin_count", id), yin_cnt, v.yins);
        chk($sformatf("v%0d t3_sel", id), t3s, v.t3_sel);
        chk($sformatf("v%0d t4_alu_op", id), t4o, v.t4_op);
        chk($sformatf("v%0d t4_sel", id), t4s, v.t4_sel);
        chk($sformatf("v%0d rin_count", id), rin_cnt, v.rins);
        chk($sformatf("v%0d rin_sel", id), rs, v.rin_sel);
        chk($sformatf("v%0d lo_hi", id), {lo_cnt[3:0], hi_cnt[3:0]}, {v.hilo[3:0], v.hilo[3:0]});
        chk($sformatf("v%0d invariants", id), bad, 0);
    endtask

    initial begin
        logic found;
        //        ir                lat yin t3     t4_op     t4s    rin rs    hilo ill
        vecs[0]  = '{32'h192B0000,  6, 1, 4'd5,  14'h0001, 4'd6,  1, 4'd2,  0, 0};
        vecs[1]  = '{32'h79A00000,  7, 1, 4'd3,  14'h0004, 4'd4,  0, 4'd0,  1, 0};
        vecs[2]  = '{32'h90B80000,  5, 0, 4'd0,  14'h1000, 4'd7,  1, 4'd1,  0, 0};
        vecs[3]  = '{32'hF8000000,  0, 0, 4'd0,  14'h0000, 4'd0,  0, 4'd0,  0, 1};
        vecs[4]  = '{mk(4, 1, 2, 3),   6, 1, 4'd2,  14'h0002, 4'd3,  1, 4'd1,  0, 0};
        vecs[5]  = '{mk(16, 9, 10, 0), 7, 1, 4'd9,  14'h0008, 4'd10, 0, 4'd0,  1, 0};
        vecs[6]  = '{mk(17, 15, 14, 0),5, 0, 4'd0,  14'h0800, 4'd14, 1, 4'd15, 0, 0};
        vecs[7]  = '{mk(9, 4, 0, 11),  6, 1, 4'd0,  14'h0400, 4'd11, 1, 4'd4,  0, 0};
        vecs[8]  = '{mk(6, 7, 8, 12),  6, 1, 4'd8,  14'h0080, 4'd12, 1, 4'd7,  0, 0};
        vecs[9]  = '{mk(11, 0, 3, 5),  6, 1, 4'd3,  14'h0020, 4'd5,  1, 4'd0,  0, 0};
        vecs[10] = '{mk(12, 1, 1, 1),  0, 0, 4'd0,  14'h0000, 4'd0,  0, 4'd0,  0, 1};
        vecs[11] = '{mk(10, 2, 6, 1),  6, 1, 4'd6,  14'h0010, 4'd1,  1, 4'd2,  0, 0};
        vecs[12] = '{mk(5, 3, 1, 2),   6, 1, 4'd1,  14'h0040, 4'd2,  1, 4'd3,  0, 0};
        vecs[13] = '{mk(7, 5, 6, 7),   6, 1, 4'd6,  14'h0100, 4'd7,  1, 4'd5,  0, 0};
        vecs[14] = '{mk(8, 8, 9, 10),  6, 1, 4'd9,  14'h0200, 4'd10, 1, 4'd8,  0, 0};
        bus.start = 1'b0;
        bus.ir = '0;
`ifdef ALU_SEQ_MEM_WAIT_EN
        bus.mem_ready = 1'b1;
`endif
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_out(), 40'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", all_out(), 40'h0);

        for (int i = 0; i < 15; i++) run(vecs[i], i, 0);

        // Abort mid-instruction: reset lands while in T4.
        @(negedge clk);
        bus.ir = vecs[0].ir;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            @(negedge clk);
            if (bus.Zin && bus.alu_op == 14'h0001) found = 1'b1;
        end
        chk("abort_reach_t4", found, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs", all_out(), 40'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_stays_idle", all_out(), 40'h0);
        run(vecs[0], 100, 0);

        // Back-to-back with start held: exactly one idle cycle between instructions.
        @(negedge clk);
        bus.ir = vecs[2].ir;
        bus.start = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (bus.done) found = 1'b1;
        end
        chk("b2b_first_done", found, 1);
        @(negedge clk);
        chk("b2b_gap_busy", bus.busy, 0);
        @(negedge clk);
        chk("b2b_relaunch_t0", {bus.PCout, bus.busy}, 2'b11);
        bus.start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (!bus.busy) found = 1'b1;
        end
        chk("b2b_return_idle", found, 1);

`ifdef ALU_SEQ_MEM_WAIT_EN
        run(vecs[0], 200, 3);
        run(vecs[1], 201, 2);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Control-step sequencer that drives the ALU's one-hot operation strobes and the surrounding datapath enables.
- Runs fetch (T0-T2) and execute (T3-T6) micro-steps for the 13 Phase 1 register-register ops.
- Sits directly upstream of the ALU. Its outputs gate the Y register, the ALU op inputs, the Z register and the HI/LO write-back.

Parameters:
- IR_W, 32, instruction register width.
- OP_W, 5, opcode width, taken from ir[IR_W-1 -: OP_W].
- SEL_W, 4, register-select field width for Ra/Rb/Rc.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request one instruction cycle; sampled only in IDLE.
- ir  in  IR_W  IR contents; fields Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].
- alu_op  out  14  one-hot strobes: [0]ADD [1]SUB [2]MUL [3]DIV [4]AND [5]OR [6]SHR [7]SHRA [8]SHL [9]ROR [10]ROL [11]NEG [12]NOT [13]IncPC.
- PCout, MARin, Zin, PCin, Read, MDRin, MDRout, IRin, Yin, Rout, Rin, Zlowout, Zhighout, LOin, HIin  out  1 each  datapath enables.
- rout_sel  out  SEL_W  register driven onto the bus when Rout=1.
- rin_sel  out  SEL_W  register written when Rin=1.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse in the final step.
- illegal  out  1  one-cycle pulse when the opcode is undefined.

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, ILL.
- Outputs are a pure decode of the state register and the latched fields op_q/ra_q/rb_q/rc_q. There is no combinational path from start or ir.
- Reset: state=IDLE, latched fields=0, every output 0. Reset asserted mid-instruction aborts it at the next edge with no done pulse.
- IDLE: all outputs 0. start=1 -> T0. start is ignored in all other states.
- T0: PCout, MARin, alu_op[13] (IncPC), Zin.
- T1: Zlowout, PCin, Read, MDRin.
- T2: MDRout, IRin. On exit, latch op_q/ra_q/rb_q/rc_q from ir.
- Opcode decode: ADD 00011, SUB 00100, SHR 00101, SHRA 00110, SHL 00111, ROR 01000, ROL 01001, AND 01010, OR 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010.
- Any other opcode: T2 -> ILL. ILL pulses illegal for one cycle, then -> IDLE.
- T2 exit targets: T3 for 3-register ops and MUL/DIV; T4 directly for NEG/NOT (no Y load).
- T3:
  - 3-register ops: Rout, rout_sel=rb_q, Yin.
  - MUL/DIV: Rout, rout_sel=ra_q, Yin.
- T4:
  - Exactly one alu_op bit for op_q, plus Zin.
  - 3-register ops: Rout, rout_sel=rc_q.
  - MUL/DIV and NEG/NOT: Rout, rout_sel=rb_q.
- T5:
  - 3-register ops and NEG/NOT: Zlowout, Rin, rin_sel=ra_q, done -> IDLE.
  - MUL/DIV: Zlowout, LOin -> T6.
- T6 (MUL/DIV only): Zhighout, HIin, done -> IDLE.
- Latency from the start-sample edge to the done cycle:
  - 6 cycles for 3-register ops.
  - 5 for NEG/NOT.
  - 7 for MUL/DIV.
- Throughput: start held high re-launches on the first IDLE cycle after done, so there is one idle cycle between instructions.
- Invariants:
  - alu_op is zero or one-hot in every cycle.
  - rout_sel and rin_sel are 0 when Rout and Rin are low.
  - At most one of Zlowout/Zhighout/MDRout/PCout/Rout is high in any cycle (bus exclusivity).

Optional Feature:
- Macro: ALU_SEQ_MEM_WAIT_EN.
- Defined: adds input port mem_ready (1 bit). T1 holds, re-asserting its outputs, until mem_ready=1, then -> T2. Reset during the wait -> IDLE.
- Undefined: no mem_ready port; T1 always lasts exactly one cycle.

Test Plan:
- reset, then start pulse with ir=0x192B0000 (ADD Ra=2 Rb=5 Rc=6):
  - T3: Rout with rout_sel=5, Yin.
  - T4: alu_op=14'h0001, rout_sel=6, Zin.
  - T5: Rin with rin_sel=2, done.
  - done lands 6 cycles after the start edge.
- ir=0x79A00000 (MUL Ra=3 Rb=4):
  - T3: rout_sel=3, Yin.
  - T4: alu_op=14'h0004, rout_sel=4.
  - T5: LOin. T6: HIin plus done.
  - Rin never asserted; latency 7.
- ir=0x90B80000 (NOT Ra=1 Rb=7):
  - Yin never asserted.
  - T4: alu_op=14'h1000, rout_sel=7.
  - T5: rin_sel=1, done.
  - Latency 5.
- ir=0xF8000000 (opcode 11111): illegal pulses once after T2, returns to IDLE, no done, no Rin.
- start issued, reset asserted in T4: next cycle all outputs 0, busy=0; a new start runs a clean T0.
- With ALU_SEQ_MEM_WAIT_EN, hold mem_ready=0 for 3 cycles: T1 outputs stay asserted 4 cycles; ADD latency becomes 9.
